dl_reg_wr_arb: RTL and testbench
================================

# dl_reg_wr_arb

Round-robin write arbiter for a shared `NUM_BITS`-wide register in the design library. Up to `NUM_REQ` requesters present write data with a valid/ready handshake. Each cycle the block grants at most one of them and loads the winner's data into the internal register on the next clock edge, using the same synchronous-reset semantics as the library registers. It is used wherever several pipeline stages update one CSR-style or status register.

## Interface
- `NUM_REQ`, default 4: number of requesters. Legal range is ≥2.
- `NUM_BITS`, default 32: width of the shared register.
- `RST_VAL`, default 0: reset value of `q`.
- `SRC_W`, derived as `$clog2(NUM_REQ)`: width of the source index. Not overridable.

Ports (clock and reset first):
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low; clock `clk`.
- `en`  in  1  arbitration enable. When 0, no grant is issued.
- `req_valid`  in  `NUM_REQ`  per-requester write request.
- `req_data`  in  `NUM_REQ*NUM_BITS`  packed data. Requester i owns bits `[i*NUM_BITS +: NUM_BITS]`.
- `req_ready`  out  `NUM_REQ`  one-hot-or-zero grant. Combinational in the current cycle.
- `q`  out  `NUM_BITS`  registered shared value.
- `q_src`  out  `SRC_W`  index of the requester that last wrote `q`.
- `q_upd`  out  1  one-cycle pulse: `q` was written on the preceding edge.

## Operation
- Internal state:
  - `ptr` [`SRC_W`]: highest-priority requester index.
  - registers for `q`, `q_src`, `q_upd`.
- Grant selection (combinational):
  - The winner is the first i with `req_valid[i]=1`, scanning `ptr, ptr+1, …, NUM_REQ-1, 0, …, ptr-1`.
  - `req_ready[winner]=1` only when `en=1`. All other bits are 0.
  - No valid request, or `en=0`: `req_ready` is all zero.
- Transfer: requester i's write completes on a rising edge where `req_valid[i] & req_ready[i]`. On that edge:
  - `q` ← requester i's data slice.
  - `q_src` ← i.
  - `q_upd` ← 1.
  - `ptr` ← (i+1) mod `NUM_REQ`. Wrap from `NUM_REQ-1` to 0. For non-power-of-2 `NUM_REQ`, `ptr` never holds an index ≥ `NUM_REQ`.
- Cycle with no transfer:
  - `q`, `q_src` and `ptr` hold.
  - `q_upd` ← 0.
- Handshake rules for requesters:
  - Once asserted, `req_valid[i]` and its data stay stable until the accepting edge.
  - `req_valid` does not depend combinationally on `req_ready`.
  - The bench checks both rules with assertions.
- A requester may keep `req_valid` high across consecutive transfers. It is then re-granted only after every other valid requester has been served once.
- Fairness: any continuously valid requester is granted within `NUM_REQ` enabled cycles.
- `en` low does not change `ptr`. Arbitration resumes from the same priority.

## Timing
- Reset (`rst_n=0` at a rising edge) sets:
  - `q=RST_VAL`, `q_src=0`, `q_upd=0`, `ptr=0`.
- Reset overrides any concurrent grant. The grant is not consumed, so the requester keeps `req_valid` and wins again after reset.
- `req_ready` is a combinational function of `req_valid`, `en`, `ptr` and `rst_n`. It is forced to 0 while `rst_n=0`.
- Write latency is 1 cycle: data accepted at edge N is visible on `q` after edge N, with `q_upd=1` during cycle N+1.
- Throughput is one write per cycle. Back-to-back writes from different requesters are allowed, giving continuous `q_upd=1`.

## Test plan
- **Reset values:** hold `rst_n=0` for 2 cycles with all `req_valid=1` and `RST_VAL=32'hA5A5_0000`. Required: `req_ready=0`, `q=32'hA5A5_0000`, `q_src=0`, `q_upd=0`.
- **Single requester:** after reset, `req_valid=4'b0100`, data2=`32'h1234`. Required: `req_ready=4'b0100` in that cycle, then next cycle `q=32'h1234`, `q_src=2`, `q_upd=1`. `ptr` becomes 3.
- **Full rotation:** all four valid continuously with data i = i+1. Required:
  - grants 0,1,2,3,0,1 on consecutive cycles;
  - `q` sequence 1,2,3,4,1,2;
  - `q_upd` held at 1.
- **Wrap-around priority:** serve requester 2 alone (`ptr`=3), then assert `req_valid=4'b1001`. Required: requester 3 granted first, then requester 0. `ptr` ends at 1.
- **Stall via en:** all valid, drop `en` for 3 cycles after the grant to requester 1. Required during the stall:
  - `req_ready=0`, `q_upd=0`;
  - `q` holds data1.
  
  After `en` returns, requester 2 is granted first.
- **Reset mid-operation:** assert `rst_n=0` in a cycle where requester 3 is granted. Required: `q=RST_VAL` and `q_src=0` after the edge, and no `q_upd` pulse. After release with `req_valid=4'b1000` still high, requester 3 is granted on the first cycle.

Source files
------------

// File: rtl/dl_reg_wr_arb.sv
// Round-robin write arbiter for a shared register: grants one valid requester per cycle
// and loads its data into q on the following edge.
module dl_reg_wr_arb #(
    parameter int unsigned          NUM_REQ  = 4,
    parameter int unsigned          NUM_BITS = 32,
    parameter logic [NUM_BITS-1:0]  RST_VAL  = '0,
    localparam int unsigned         SRC_W    = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*NUM_BITS-1:0]  req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_BITS-1:0]          q,
    output logic [SRC_W-1:0]             q_src,
    output logic                         q_upd
);

    logic [SRC_W-1:0]    ptr;
    logic [SRC_W-1:0]    win_idx;
    logic [SRC_W-1:0]    cand;
    logic                found;
    int unsigned         idx;
    logic [NUM_BITS-1:0] data_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign data_arr[g] = req_data[g*NUM_BITS +: NUM_BITS];
    end

    // Scan from ptr upward with wrap; the first valid requester wins.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            cand = SRC_W'(idx);
            if (!found && req_valid[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && en && found) begin
            req_ready = NUM_REQ'(1) << win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q     <= RST_VAL;
            q_src <= '0;
            q_upd <= 1'b0;
            ptr   <= '0;
        end else if (en && found) begin
            q     <= data_arr[win_idx];
            q_src <= win_idx;
            q_upd <= 1'b1;
            // Explicit wrap keeps ptr in range for non-power-of-2 NUM_REQ.
            if (32'(win_idx) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= win_idx + 1'b1;
            end
        end else begin
            q_upd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dl_reg_wr_arb.sv
// Self-checking bench for dl_reg_wr_arb: directed scenarios plus randomized traffic
// against a round-robin reference model.
module tb_dl_reg_wr_arb;

    localparam logic [31:0] RV = 32'hA5A5_0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic [31:0]  q;
    logic [1:0]   q_src;
    logic         q_upd;

    logic [31:0]  d [4];
    int           checks = 0;
    int           errors = 0;
    bit           hs_chk = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < 4; i++) req_data[i*32 +: 32] = d[i];
    end

    dl_reg_wr_arb #(
        .NUM_REQ  (4),
        .NUM_BITS (32),
        .RST_VAL  (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .q         (q),
        .q_src     (q_src),
        .q_upd     (q_upd)
    );

    // Requester-side handshake rules: a pending request and its data stay put until accepted.
    logic [3:0]  hv;
    logic [3:0]  hacc;
    logic [31:0] hd [4];
    bit          hval = 1'b0;
    always @(posedge clk) begin
        if (hs_chk && hval) begin
            for (int i = 0; i < 4; i++) begin
                if (hv[i] && !hacc[i]) begin
                    assert (req_valid[i]) else $error("handshake: valid %0d dropped", i);
                    assert (d[i] == hd[i]) else $error("handshake: data %0d changed", i);
                end
            end
        end
        hv   <= req_valid;
        hacc <= req_valid & req_ready;
        hd   <= d;
        hval <= hs_chk;
    end

    // Reference model
    int          m_ptr;
    logic [31:0] m_q;
    int          m_src;
    bit          m_upd;

    function automatic int winner(logic [3:0] v, int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL reset_ready: got %b want 0000", req_ready);
            end
        end
        checks++;
        if (q !== RV) begin errors++; $display("FAIL reset_q: got %h want %h", q, RV); end
        checks++;
        if (q_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", q_src); end
        checks++;
        if (q_upd !== 1'b0) begin errors++; $display("FAIL reset_upd: got %b want 0", q_upd); end
    endtask

    task automatic test_single();
        rst_n = 1'b1;
        req_valid = 4'b0100;
        d[2] = 32'h1234;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'h1234 || q_src !== 2'd2 || q_upd !== 1'b1) begin
            errors++;
            $display("FAIL single_q: got q=%h src=%0d upd=%b want 1234/2/1", q, q_src, q_upd);
        end
    endtask

    task automatic test_wrap();
        req_valid = 4'b1001;
        d[3] = 32'hCAFE_0003;
        d[0] = 32'hCAFE_0000;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first: got %b want 1000", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'hCAFE_0003 || q_src !== 2'd3) begin
            errors++;
            $display("FAIL wrap_q3: got q=%h src=%0d want cafe0003/3", q, q_src);
        end
        req_valid = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second: got %b want 0001", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'hCAFE_0000 || q_src !== 2'd0 || q_upd !== 1'b1) begin
            errors++;
            $display("FAIL wrap_q0: got q=%h src=%0d upd=%b want cafe0000/0/1", q, q_src, q_upd);
        end
        // ptr should now be 1: with everyone valid, requester 1 wins.
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL wrap_ptr: got %b want 0010", req_ready);
        end
        req_valid = 4'h0;
        #1;
    endtask

    task automatic test_rotation();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) d[i] = 32'(i + 1);
        for (int c = 0; c < 6; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'(1 << (c % 4))) begin
                errors++;
                $display("FAIL rot_grant%0d: got %b want %b", c, req_ready, 4'(1 << (c % 4)));
            end
            @(negedge clk);
            checks++;
            if (q !== 32'((c % 4) + 1) || q_src !== 2'(c % 4) || q_upd !== 1'b1) begin
                errors++;
                $display("FAIL rot_q%0d: got q=%0d src=%0d upd=%b want %0d/%0d/1",
                         c, q, q_src, q_upd, (c % 4) + 1, c % 4);
            end
        end
    endtask

    task automatic test_stall();
        en = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL stall_ready%0d: got %b want 0000", s, req_ready);
            end
            @(negedge clk);
            checks++;
            if (q_upd !== 1'b0 || q !== 32'd2) begin
                errors++;
                $display("FAIL stall_hold%0d: got q=%0d upd=%b want 2/0", s, q, q_upd);
            end
        end
        en = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL stall_resume: got %b want 0100", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'd3 || q_src !== 2'd2) begin
            errors++;
            $display("FAIL stall_q: got q=%0d src=%0d want 3/2", q, q_src);
        end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1000;
        d[3] = 32'h0BAD_F00D;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rmid_pre: got %b want 1000", req_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_mask: got %b want 0000", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== RV || q_src !== 2'd0 || q_upd !== 1'b0) begin
            errors++;
            $display("FAIL rmid_reset: got q=%h src=%0d upd=%b want %h/0/0", q, q_src, q_upd, RV);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++;
            $display("FAIL rmid_regrant: got %b want 1000", req_ready);
        end
        @(negedge clk);
        checks++;
        if (q !== 32'h0BAD_F00D || q_src !== 2'd3 || q_upd !== 1'b1) begin
            errors++;
            $display("FAIL rmid_q: got q=%h src=%0d upd=%b want 0badf00d/3/1", q, q_src, q_upd);
        end
        req_valid = 4'h0;
    endtask

    task automatic test_random();
        int w;
        int acc;
        logic [3:0] exp_ready;
        rst_n = 1'b0;
        req_valid = 4'h0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
        m_q = RV;
        m_src = 0;
        m_upd = 1'b0;
        acc = -1;
        hs_chk = 1'b1;
        for (int n = 0; n < 500; n++) begin
            rst_n = ($urandom_range(0, 39) != 0);
            en = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] || acc == i) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    d[i] = $urandom;
                end
            end
            #1;
            w = winner(req_valid, m_ptr);
            exp_ready = (rst_n && en && w >= 0) ? 4'(1 << w) : 4'b0000;
            checks++;
            if (req_ready !== exp_ready) begin
                errors++;
                $display("FAIL rand_ready@%0d: got %b want %b", n, req_ready, exp_ready);
            end
            if (!rst_n) begin
                m_ptr = 0; m_q = RV; m_src = 0; m_upd = 1'b0;
            end else if (exp_ready != 0) begin
                m_q = d[w]; m_src = w; m_upd = 1'b1; m_ptr = (w + 1) % 4;
            end else begin
                m_upd = 1'b0;
            end
            acc = (exp_ready != 0) ? w : -1;
            @(negedge clk);
            checks++;
            if (q !== m_q || q_src !== 2'(m_src) || q_upd !== m_upd) begin
                errors++;
                $display("FAIL rand_q@%0d: got q=%h src=%0d upd=%b want %h/%0d/%b",
                         n, q, q_src, q_upd, m_q, m_src, m_upd);
            end
        end
        hs_chk = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_rotation();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
